// File: rtl/ex_muldiv_unit_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
// Helper functions are sized for the 32-bit datapath (MD_XLEN).
package muldiv_pkg;

    localparam int MD_XLEN = 32;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        RUN,
        FIN,
        DONE
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    function automatic logic is_signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    // Two's-complement negate when the result sign says so.
    function automatic logic [MD_XLEN-1:0] sign_fix_word(input logic [MD_XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*MD_XLEN-1:0] sign_fix_wide(input logic [2*MD_XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage handshake between the decode/execute register and the mul/div unit.
interface ex_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd_in;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, flush, funct3, op_a, op_b, rd_in,
        input  stall, done, result, rd_out
    );

    modport slave (
        input  start, flush, funct3, op_a, op_b, rd_in,
        output stall, done, result, rd_out
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shared add/subtract datapath,
// radix-2 shift-add multiply and restoring divide, stalls the pipeline while busy.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic clk,
    input  logic rst,
    ex_muldiv_unit_if.slave bus
);

    state_t            state;
    logic [2:0]        f3_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic              neg_quo;
    logic              neg_rem;
    logic [CNT_W-1:0]  cnt;
    logic [4:0]        rd_lat;
    logic              done_q;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        rd_out_q;

    logic              div_op;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN+1:0]   add_x;
    logic [XLEN+1:0]   add_y;
    logic [XLEN+1:0]   add_sum;
    logic              div_fits;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fin_val;

    // Operand magnitudes and special cases, valid while the raw operands sit in a_q/b_q (PREP).
    always_comb begin
        div_op   = is_div(f3_q);
        a_neg    = is_signed_a(f3_q) && a_q[XLEN-1];
        b_neg    = is_signed_b(f3_q) && b_q[XLEN-1];
        a_mag    = a_neg ? -a_q : a_q;
        b_mag    = b_neg ? -b_q : b_q;
        div_zero = div_op && (b_q == '0);
        div_ovf  = div_op && is_signed_a(f3_q) &&
                   (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
    end

    // Shared adder: hi + multiplicand for multiply, {hi,next dividend bit} - divisor for divide.
    always_comb begin
        add_x    = div_op ? {1'b0, hi_q, lo_q[XLEN-1]} : {2'b00, hi_q};
        add_y    = div_op ? ~{2'b00, b_q} : {2'b00, a_q};
        add_sum  = add_x + add_y + {{(XLEN+1){1'b0}}, div_op};
        div_fits = ~add_sum[XLEN+1];
        mul_next = lo_q[0] ? {add_sum[XLEN:0], lo_q[XLEN-1:1]}
                           : {1'b0, hi_q, lo_q[XLEN-1:1]};
    end

    always_comb begin
        prod_fix = sign_fix_wide({hi_q, lo_q}, neg_quo);
        quo_fix  = sign_fix_word(lo_q, neg_quo);
        rem_fix  = sign_fix_word(hi_q, neg_rem);
        fin_val  = rem_fix;
        case (f3_q)
            F3_MUL:                        fin_val = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  fin_val = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               fin_val = quo_fix;
            default:                       fin_val = rem_fix;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            f3_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            cnt      <= '0;
            rd_lat   <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        f3_q   <= bus.funct3;
                        a_q    <= bus.op_a;
                        b_q    <= bus.op_b;
                        rd_lat <= bus.rd_in;
                        state  <= PREP;
                    end
                end
                PREP: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        a_q     <= a_mag;
                        b_q     <= b_mag;
                        hi_q    <= '0;
                        neg_quo <= a_neg ^ b_neg;
                        neg_rem <= div_op && a_neg;
                        cnt     <= CNT_W'(XLEN);
                        state   <= RUN;
                        lo_q    <= div_op ? a_mag : b_mag;
                        // Division corner cases finish without iterating; FIN applies no sign.
                        if (div_zero) begin
                            hi_q    <= a_q;
                            lo_q    <= '1;
                            neg_quo <= 1'b0;
                            neg_rem <= 1'b0;
                            state   <= FIN;
                        end else if (div_ovf) begin
                            lo_q    <= {1'b1, {(XLEN-1){1'b0}}};
                            neg_quo <= 1'b0;
                            neg_rem <= 1'b0;
                            state   <= FIN;
                        end
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        if (div_op) begin
                            hi_q <= div_fits ? add_sum[XLEN-1:0] : {hi_q[XLEN-2:0], lo_q[XLEN-1]};
                            lo_q <= {lo_q[XLEN-2:0], div_fits};
                        end else begin
                            {hi_q, lo_q} <= mul_next;
                        end
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= FIN;
                        end
                    end
                end
                FIN: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        result_q <= fin_val;
                        rd_out_q <= rd_lat;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.stall  = (state == PREP) || (state == RUN) || (state == FIN) ||
                        ((state == IDLE) && bus.start);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: scoreboard of expected results from
// an independent 64-bit arithmetic model, checked on each done pulse.
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

    logic clk;
    logic rst;

    ex_muldiv_unit_if #(.XLEN(32)) bus ();

    ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [36:0] sb_q[$];
    logic [31:0] last_exp_result = '0;
    logic [4:0]  last_exp_rd     = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        longint      q;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'h0, b});
        case (f3)
            3'b000: begin p = 64'(sa * sb); return p[31:0]; end
            3'b001: begin p = 64'(sa * sb); return p[63:32]; end
            3'b010: begin p = 64'(sa * ub); return p[63:32]; end
            3'b011: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = sa / sb;
                return q[31:0];
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                q = sa % sb;
                return q[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Drives one instruction, holds start through DONE like the pipeline register would.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        int          lat;
        int          stall_cnt;
        int          exp_lat;
        bit          got;
        logic [36:0] exp_entry;
        exp_lat = (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 3 : 35;
        sb_q.push_back({rd, ref_model(f3, a, b)});
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.rd_in  = rd;
        bus.start  = 1'b1;
        #1;
        vectors++;
        if (bus.stall !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL stall_on_start f3=%b: got %b, want 1", f3, bus.stall);
        end
        lat = 0;
        stall_cnt = 0;
        got = 0;
        while (!got && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done === 1'b1) got = 1;
            else if (bus.stall === 1'b1) stall_cnt++;
        end
        exp_entry = sb_q.pop_front();
        vectors++;
        if (!got) begin
            miscompares++;
            $display("[TB] FAIL done_timeout f3=%b: no done within %0d cycles", f3, lat);
            bus.start = 1'b0;
            return;
        end
        if (lat != exp_lat) begin
            miscompares++;
            $display("[TB] FAIL latency f3=%b: got %0d, want %0d", f3, lat, exp_lat);
        end
        vectors++;
        if (stall_cnt != exp_lat - 1) begin
            miscompares++;
            $display("[TB] FAIL stall_cycles f3=%b: got %0d, want %0d", f3, stall_cnt, exp_lat - 1);
        end
        vectors++;
        if (bus.stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stall_in_done f3=%b: got %b, want 0", f3, bus.stall);
        end
        vectors++;
        if (bus.result !== exp_entry[31:0]) begin
            miscompares++;
            $display("[TB] FAIL result f3=%b a=%h b=%h: got %h, want %h", f3, a, b, bus.result, exp_entry[31:0]);
        end
        vectors++;
        if (bus.rd_out !== exp_entry[36:32]) begin
            miscompares++;
            $display("[TB] FAIL rd_out f3=%b: got %0d, want %0d", f3, bus.rd_out, exp_entry[36:32]);
        end
        last_exp_result = exp_entry[31:0];
        last_exp_rd     = exp_entry[36:32];
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        #1;
        vectors++;
        if (bus.done !== 1'b0 || bus.stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_pulse f3=%b: got done=%b stall=%b, want 0 0", f3, bus.done, bus.stall);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus.done !== 1'b0 || bus.stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got done=%b stall=%b, want 0 0", bus.done, bus.stall);
        end
        vectors++;
        if (bus.result !== 32'h0 || bus.rd_out !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got result=%h rd=%0d, want 0 0", bus.result, bus.rd_out);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mul();
        do_op(F3_MUL, 32'd7, 32'd6, 5'd5);
        do_op(F3_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
        do_op(F3_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 5'd31);
    endtask

    task automatic test_mul_high();
        do_op(F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        do_op(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        do_op(F3_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd4);
        do_op(F3_MULH,   32'h8000_0000, 32'h8000_0000, 5'd6);
    endtask

    task automatic test_div();
        do_op(F3_DIV,  32'hFFFF_FFF9, 32'd2, 5'd8);
        do_op(F3_REM,  32'hFFFF_FFF9, 32'd2, 5'd9);
        do_op(F3_DIVU, 32'd100,       32'd7, 5'd10);
        do_op(F3_REMU, 32'd100,       32'd7, 5'd11);
        do_op(F3_REM,  32'd7,  32'hFFFF_FFFE, 5'd12);
    endtask

    task automatic test_special();
        do_op(F3_DIV,  32'd5,         32'd0,         5'd13);
        do_op(F3_REMU, 32'd5,         32'd0,         5'd14);
        do_op(F3_REM,  32'hFFFF_FFFB, 32'd0,         5'd15);
        do_op(F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd16);
        do_op(F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd17);
    endtask

    task automatic test_flush();
        bit saw_done;
        bus.funct3 = F3_MUL;
        bus.op_a   = 32'd3;
        bus.op_b   = 32'd4;
        bus.rd_in  = 5'd9;
        bus.start  = 1'b1;
        for (int k = 0; k < 11; k++) begin
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        vectors++;
        if (bus.stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_stall: got %b, want 0", bus.stall);
        end
        saw_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) saw_done = 1;
        end
        vectors++;
        if (saw_done) begin
            miscompares++;
            $display("[TB] FAIL flush_no_done: got done pulse, want none");
        end
        vectors++;
        if (bus.result !== last_exp_result || bus.rd_out !== last_exp_rd) begin
            miscompares++;
            $display("[TB] FAIL flush_hold: got %h/%0d, want %h/%0d", bus.result, bus.rd_out, last_exp_result, last_exp_rd);
        end
        do_op(F3_MUL, 32'd3, 32'd4, 5'd9);
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        bus.funct3 = F3_DIVU;
        bus.op_a   = 32'd1000;
        bus.op_b   = 32'd3;
        bus.rd_in  = 5'd7;
        bus.start  = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        rst       = 1'b1;
        bus.start = 1'b0;
        #1;
        vectors++;
        if (bus.done !== 1'b0 || bus.stall !== 1'b0 || bus.result !== 32'h0 || bus.rd_out !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset: got done=%b stall=%b result=%h rd=%0d, want all 0",
                     bus.done, bus.stall, bus.result, bus.rd_out);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_exp_result = '0;
        last_exp_rd     = '0;
        do_op(F3_DIVU, 32'd1000, 32'd3, 5'd7);
        saw_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) saw_done = 1;
        end
        vectors++;
        if (saw_done) begin
            miscompares++;
            $display("[TB] FAIL extra_done: got extra done pulse, want none");
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 10; i++) begin
            f3 = 3'($urandom_range(7, 0));
            a  = $urandom();
            case ($urandom_range(3, 0))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(15, 1));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom();
            endcase
            do_op(f3, a, b, 5'(i + 18));
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = '0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        bus.rd_in  = '0;
        test_reset();
        test_mul();
        test_mul_high();
        test_div();
        test_special();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage.
- Consumes the operand, rd and funct3 outputs of the decode/execute pipeline register, and drives a stall back upstream so that register holds the instruction until the result is ready.
- Uses one shared shift/add/subtract datapath for all 8 M-extension ops.
- Returns the result with rd toward the EX/MEM register.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must hold the value XLEN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  valid M-type instruction present in EX (from the decode/execute register).
- flush  in  1  kill the current instruction (branch/jump redirect).
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 value (already forwarded).
- op_b  in  XLEN  rs2 value (already forwarded).
- rd_in  in  5  destination register.
- stall  out  1  hold the decode/execute register and the earlier stages.
- done  out  1  one-cycle pulse: result and rd_out valid.
- result  out  XLEN  operation result.
- rd_out  out  5  latched rd.

Behaviour:
- Reset (async, rst=1): state=IDLE; done=0, result=0, rd_out=0, counter=0, all internal registers 0; stall=0.
- States: IDLE, PREP, RUN, FIN, DONE.
- IDLE:
  - start=1: latch funct3, op_a, op_b, rd_in, then go to PREP.
  - stall is driven combinationally = start, so the register holds in the same cycle.
- PREP (1 cycle):
  - Compute operand magnitudes and result sign per op signedness.
  - Division special cases, resolved here and skipping RUN:
    - op_b=0: quotient=0xFFFFFFFF, remainder=op_a.
    - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF, DIV/REM): quotient=0x80000000, remainder=0.
  - Otherwise load counter=XLEN and go to RUN.
- RUN (XLEN cycles):
  - Multiply: shift-add radix-2, 64-bit product.
  - Divide: restoring, 1 quotient bit per cycle.
  - Counter decrements each cycle; at counter==1, go to FIN.
- FIN (1 cycle):
  - Apply sign correction (two's complement).
  - Select the product high/low half, quotient or remainder; register into result.
  - Go to DONE.
- DONE (1 cycle): done=1, stall=0 so the pipeline advances. start is ignored in this cycle (it is the same held instruction). Next state IDLE.
- stall = (state in PREP, RUN, FIN) OR (state==IDLE AND start).
- Latency, start edge to done:
  - Normal ops: 1+32+1+1 = 35 cycles.
  - Special-case division: 3 cycles.
- Sign rules:
  - MULH: both operands signed.
  - MULHSU: op_a signed, op_b unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - Remainder takes the dividend's sign.
- flush=1 in any state except DONE: next state IDLE, no done pulse, result unchanged. flush in IDLE with start=1: the op is not accepted. flush in DONE: done still pulses, because the pipeline has already advanced.
- rst asserted mid-operation: immediate return to IDLE and reset values; no done.
- result and rd_out hold their value after DONE until the next FIN.
- Arithmetic is modulo 2^XLEN; MUL returns product[31:0].

Decomposition:
- Package muldiv_pkg contains:
  - state_t enum (IDLE, PREP, RUN, FIN, DONE).
  - funct3 localparams (F3_MUL … F3_REMU).
  - is_signed_a / is_signed_b / is_div helper functions.
- No sub-module is needed. The FSM and datapath stay in one module; sign-fix logic is a package function.

Test Plan:
- MUL 7 × 6 (funct3=000): stall held 34 cycles; done at cycle 35; result=0x0000002A; rd_out=rd_in=5.
- MULH 0xFFFFFFFF × 0xFFFFFFFF: result=0x00000000. MULHU, same operands: result=0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2: result=0xFFFFFFFF.
- DIV −7/2: result=0xFFFFFFFD. REM −7/2: result=0xFFFFFFFF. DIVU 100/7: result=14. REMU 100/7: result=2.
- Special cases:
  - DIV 5/0: done at cycle 3, result=0xFFFFFFFF.
  - REMU 5/0: result=5.
  - DIV 0x80000000/0xFFFFFFFF: result=0x80000000, done at cycle 3.
- flush asserted at RUN cycle 10: stall drops next cycle, no done pulse, result keeps its previous value. A new start then completes normally.
- rst pulsed at RUN cycle 5: all outputs 0 immediately. With start held high through DONE, exactly one done pulse occurs per accepted start.
